// File: rtl/md_timestep_controller_pkg.sv
// Shared state encoding and default timing constants for the MD timestep controller.
// The controller FSM and both phase handshake instances import this package.
package md_timestep_controller_pkg;

    localparam int STEP_W_DEF       = 32;
    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int WDOG_W_DEF       = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_P1_RUN   = 3'd1,
        ST_P1_DRAIN = 3'd2,
        ST_P2_RUN   = 3'd3,
        ST_P2_DRAIN = 3'd4,
        ST_SWAP     = 3'd5,
        ST_FINISH   = 3'd6,
        ST_ERROR    = 3'd7
    } ctl_state_e;

    function automatic logic isBusyState(input ctl_state_e s);
        return !(s == ST_IDLE || s == ST_ERROR);
    endfunction

endpackage

// File: rtl/md_timestep_controller_if.sv
// Control/status bundle between the timestep controller and its environment
// (host start/abort, both phase READY/DONE pairs, cache buffer select).
interface md_timestep_controller_if
    import md_timestep_controller_pkg::*;
#(
    parameter int STEP_W = STEP_W_DEF
);

    logic              start;
    logic              abort;
    logic [STEP_W-1:0] num_steps;
    logic              p1_ready;
    logic              p1_done;
    logic              p2_ready;
    logic              p2_done;
    logic              double_buffer;
    logic              busy;
    logic [STEP_W-1:0] step_count;
    logic              done;
    logic              err;

    modport master (
        output start, abort, num_steps, p1_done, p2_done,
        input  p1_ready, p2_ready, double_buffer, busy, step_count, done, err
    );

    modport slave (
        input  start, abort, num_steps, p1_done, p2_done,
        output p1_ready, p2_ready, double_buffer, busy, step_count, done, err
    );

endinterface

// File: rtl/md_timestep_controller_phase_handshake.sv
// One phase's READY/DONE handshake: ready register, stale-DONE arm flag,
// accepted-done strobe, post-phase drain counter and RUN watchdog.
module md_phase_handshake
    import md_timestep_controller_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int WDOG_W       = WDOG_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic runNext_i,
    input  logic inDrain_i,
    input  logic done_i,
    output logic ready_o,
    output logic accept_o,
    output logic drainLast_o,
    output logic wdogHit_o
);

    localparam int                  DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    // Expiry fires on the edge that completes 2**WDOG_W-1 cycles spent in RUN.
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = {{(WDOG_W-1){1'b1}}, 1'b0};

    logic               ready_q, ready_d;
    logic               armed_q, armed_d;
    logic [DRAIN_W-1:0] drainCnt_q, drainCnt_d;
    logic [WDOG_W-1:0]  wdogCnt_q, wdogCnt_d;
    logic               enterRun;

    assign enterRun = runNext_i && !ready_q;

    always_comb begin
        ready_d    = runNext_i;
        armed_d    = armed_q;
        drainCnt_d = '0;
        wdogCnt_d  = wdogCnt_q;
        if (enterRun) begin
            armed_d   = 1'b0;
            wdogCnt_d = '0;
        end else if (ready_q) begin
            if (!done_i) begin
                armed_d = 1'b1;
            end
            wdogCnt_d = wdogCnt_q + WDOG_W'(1);
        end
        if (inDrain_i) begin
            drainCnt_d = drainCnt_q + DRAIN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q    <= 1'b0;
            armed_q    <= 1'b0;
            drainCnt_q <= '0;
            wdogCnt_q  <= '0;
        end else begin
            ready_q    <= ready_d;
            armed_q    <= armed_d;
            drainCnt_q <= drainCnt_d;
            wdogCnt_q  <= wdogCnt_d;
        end
    end

    assign ready_o     = ready_q;
    assign accept_o    = ready_q && armed_q && done_i;
    assign drainLast_o = inDrain_i && (drainCnt_q == DRAIN_LAST);
    assign wdogHit_o   = ready_q && (wdogCnt_q == WDOG_LAST);

endmodule

// File: rtl/md_timestep_controller.sv
// Timestep sequencer: alternates force phase and motion-update phase for a
// programmed number of steps, flipping the cache double-buffer after each step.
module md_timestep_controller
    import md_timestep_controller_pkg::*;
#(
    parameter int STEP_W       = STEP_W_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int WDOG_W       = WDOG_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    md_timestep_controller_if.slave   bus
);

    ctl_state_e        state_q, state_d;
    logic [STEP_W-1:0] numSteps_q, numSteps_d;
    logic [STEP_W-1:0] stepCount_q, stepCount_d;
    logic              doubleBuffer_q, doubleBuffer_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              startOk;

    logic p1Ready, p1Accept, p1DrainLast, p1WdogHit;
    logic p2Ready, p2Accept, p2DrainLast, p2WdogHit;

    md_phase_handshake #(.DRAIN_CYCLES(DRAIN_CYCLES), .WDOG_W(WDOG_W)) u_p1 (
        .clk        (clk),
        .reset      (reset),
        .runNext_i  (state_d == ST_P1_RUN),
        .inDrain_i  (state_q == ST_P1_DRAIN),
        .done_i     (bus.p1_done),
        .ready_o    (p1Ready),
        .accept_o   (p1Accept),
        .drainLast_o(p1DrainLast),
        .wdogHit_o  (p1WdogHit)
    );

    md_phase_handshake #(.DRAIN_CYCLES(DRAIN_CYCLES), .WDOG_W(WDOG_W)) u_p2 (
        .clk        (clk),
        .reset      (reset),
        .runNext_i  (state_d == ST_P2_RUN),
        .inDrain_i  (state_q == ST_P2_DRAIN),
        .done_i     (bus.p2_done),
        .ready_o    (p2Ready),
        .accept_o   (p2Accept),
        .drainLast_o(p2DrainLast),
        .wdogHit_o  (p2WdogHit)
    );

    // Abort outranks everything; within RUN an accepted done outranks watchdog expiry.
    always_comb begin
        state_d = state_q;
        startOk = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (bus.start) begin
                        startOk = 1'b1;
                        state_d = (bus.num_steps == '0) ? ST_FINISH : ST_P1_RUN;
                    end
                end
                ST_P1_RUN: begin
                    if (p1Accept)       state_d = ST_P1_DRAIN;
                    else if (p1WdogHit) state_d = ST_ERROR;
                end
                ST_P1_DRAIN: if (p1DrainLast) state_d = ST_P2_RUN;
                ST_P2_RUN: begin
                    if (p2Accept)       state_d = ST_P2_DRAIN;
                    else if (p2WdogHit) state_d = ST_ERROR;
                end
                ST_P2_DRAIN: if (p2DrainLast) state_d = ST_SWAP;
                ST_SWAP:   state_d = (stepCount_q == numSteps_q) ? ST_FINISH : ST_P1_RUN;
                ST_FINISH: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        numSteps_d     = startOk ? bus.num_steps : numSteps_q;
        stepCount_d    = stepCount_q;
        doubleBuffer_d = doubleBuffer_q;
        err_d          = err_q;
        if (startOk) begin
            stepCount_d = '0;
            err_d       = 1'b0;
        end
        if (state_d == ST_SWAP) begin
            stepCount_d    = stepCount_q + STEP_W'(1);
            doubleBuffer_d = ~doubleBuffer_q;
        end
        if (state_d == ST_ERROR) begin
            err_d = 1'b1;
        end
        busy_d = isBusyState(state_d);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            numSteps_q     <= '0;
            stepCount_q    <= '0;
            doubleBuffer_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            numSteps_q     <= numSteps_d;
            stepCount_q    <= stepCount_d;
            doubleBuffer_q <= doubleBuffer_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign bus.p1_ready      = p1Ready;
    assign bus.p2_ready      = p2Ready;
    assign bus.double_buffer = doubleBuffer_q;
    assign bus.busy          = busy_q;
    assign bus.step_count    = stepCount_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

endmodule

// File: tb/tb_md_timestep_controller.sv
// Randomized self-checking bench: phase models answer READY after random latencies and
// a timeline model predicts every ready edge, buffer flip and done pulse by cycle number.
`timescale 1ns/1ps
module tb_md_timestep_controller;

    localparam int STEP_W       = 32;
    localparam int DRAIN        = 4;
    localparam int WDOG_W       = 6;
    localparam int WDOG_TIMEOUT = (1 << WDOG_W) - 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    md_timestep_controller_if #(.STEP_W(STEP_W)) bus ();

    md_timestep_controller #(
        .STEP_W      (STEP_W),
        .DRAIN_CYCLES(DRAIN),
        .WDOG_W      (WDOG_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;

    int p1Lat[$];
    int p2Lat[$];
    int p1Cnt = 0;
    int p2Cnt = 0;
    bit p1Pending = 1'b0;
    bit p2Pending = 1'b0;
    bit p1Hold    = 1'b0;
    logic prevP1 = 1'b0, prevP2 = 1'b0, prevDb = 1'b0, prevErr = 1'b0;
    bit expDb = 1'b0;

    int p1RiseLog[$], p1FallLog[$], p2RiseLog[$], p2FallLog[$];
    int dbLog[$], doneLog[$], errLog[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic compareLog(input string tag, input int got[$], input int exp[$]);
        checkOutput({tag, ".count"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
        end
    endtask

    task automatic clearLogs();
        p1RiseLog.delete(); p1FallLog.delete(); p2RiseLog.delete(); p2FallLog.delete();
        dbLog.delete(); doneLog.delete(); errLog.delete();
        p1Lat.delete(); p2Lat.delete();
    endtask

    // One clock: sample just after the edge, log output events, then let the phase models react.
    task automatic advanceCycle();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.p1_ready && !prevP1) p1RiseLog.push_back(cyc);
        if (!bus.p1_ready && prevP1) p1FallLog.push_back(cyc);
        if (bus.p2_ready && !prevP2) p2RiseLog.push_back(cyc);
        if (!bus.p2_ready && prevP2) p2FallLog.push_back(cyc);
        if (bus.double_buffer !== prevDb) dbLog.push_back(cyc);
        if (bus.done) doneLog.push_back(cyc);
        if (bus.err && !prevErr) errLog.push_back(cyc);

        if (bus.p1_ready && !prevP1 && !p1Hold) begin
            p1Pending = 1'b1;
            if (p1Lat.size() > 0) p1Cnt = p1Lat.pop_front();
            else p1Cnt = 100000;
        end else if (p1Pending && bus.p1_ready) begin
            p1Cnt--;
            if (p1Cnt == 0) begin
                bus.p1_done = 1'b1;
                p1Pending   = 1'b0;
            end
        end
        if (!bus.p1_ready) begin
            p1Pending = 1'b0;
            if (!p1Hold) bus.p1_done = 1'b0;
        end

        if (bus.p2_ready && !prevP2) begin
            p2Pending = 1'b1;
            if (p2Lat.size() > 0) p2Cnt = p2Lat.pop_front();
            else p2Cnt = 100000;
        end else if (p2Pending && bus.p2_ready) begin
            p2Cnt--;
            if (p2Cnt == 0) begin
                bus.p2_done = 1'b1;
                p2Pending   = 1'b0;
            end
        end
        if (!bus.p2_ready) begin
            p2Pending   = 1'b0;
            bus.p2_done = 1'b0;
        end

        prevP1  = bus.p1_ready;
        prevP2  = bus.p2_ready;
        prevDb  = bus.double_buffer;
        prevErr = bus.err;
    endtask

    task automatic pulseStart(input int n, output int s);
        bus.num_steps = STEP_W'(n);
        bus.start     = 1'b1;
        advanceCycle();
        bus.start = 1'b0;
        s = cyc;
    endtask

    // Full run of n steps; fixedLat==0 picks random phase latencies.
    task automatic applyStimulus(input int n, input int fixedLat);
        int l1[$], l2[$];
        int e1r[$], e1f[$], e2r[$], e2f[$], edb[$], edone[$];
        int s, t;
        clearLogs();
        for (int i = 0; i < n; i++) begin
            l1.push_back((fixedLat != 0) ? fixedLat : int'($urandom_range(12, 1)));
            l2.push_back((fixedLat != 0) ? fixedLat : int'($urandom_range(12, 1)));
            p1Lat.push_back(l1[i]);
            p2Lat.push_back(l2[i]);
        end
        pulseStart(n, s);
        checkOutput("errClearedOnStart", 64'(bus.err), 64'(0));
        checkOutput("stepCountClearedOnStart", 64'(bus.step_count), 64'(0));
        t = s;
        for (int i = 0; i < n; i++) begin
            e1r.push_back(t);
            t += l1[i] + 1;
            e1f.push_back(t);
            t += DRAIN;
            e2r.push_back(t);
            t += l2[i] + 1;
            e2f.push_back(t);
            t += DRAIN;
            edb.push_back(t);
            t += 1;
        end
        edone.push_back(t);
        while (cyc < t + 3) advanceCycle();
        compareLog($sformatf("run%0d.p1Rise", n), p1RiseLog, e1r);
        compareLog($sformatf("run%0d.p1Fall", n), p1FallLog, e1f);
        compareLog($sformatf("run%0d.p2Rise", n), p2RiseLog, e2r);
        compareLog($sformatf("run%0d.p2Fall", n), p2FallLog, e2f);
        compareLog($sformatf("run%0d.dbToggle", n), dbLog, edb);
        compareLog($sformatf("run%0d.done", n), doneLog, edone);
        expDb = expDb ^ n[0];
        checkOutput("runStepCount", 64'(bus.step_count), 64'(n));
        checkOutput("runBusyLowAfter", 64'(bus.busy), 64'(0));
        checkOutput("runDoubleBuffer", 64'(bus.double_buffer), 64'(expDb));
        checkOutput("runErrLow", 64'(bus.err), 64'(0));
    endtask

    initial begin
        int s, t, r2, a1, target;
        int la[$], lb[$];
        int expQ[$];
        bus.start = 1'b0; bus.abort = 1'b0; bus.num_steps = '0;
        bus.p1_done = 1'b0; bus.p2_done = 1'b0;
        reset = 1'b0;
        repeat (3) advanceCycle();
        checkOutput("resetBusy", 64'(bus.busy), 64'(0));
        checkOutput("resetP1Ready", 64'(bus.p1_ready), 64'(0));
        checkOutput("resetP2Ready", 64'(bus.p2_ready), 64'(0));
        checkOutput("resetDone", 64'(bus.done), 64'(0));
        checkOutput("resetErr", 64'(bus.err), 64'(0));
        checkOutput("resetDb", 64'(bus.double_buffer), 64'(0));
        checkOutput("resetStepCount", 64'(bus.step_count), 64'(0));
        reset = 1'b1;
        advanceCycle();

        applyStimulus(2, 10);
        repeat (3) applyStimulus(int'($urandom_range(4, 1)), 0);

        // Stale DONE held high before start must be ignored until it drops.
        clearLogs();
        p1Hold = 1'b1;
        bus.p1_done = 1'b1;
        advanceCycle();
        pulseStart(1, s);
        repeat (3) advanceCycle();
        checkOutput("staleDoneIgnored", 64'(bus.p1_ready), 64'(1));
        bus.p1_done = 1'b0;
        repeat (5) advanceCycle();
        checkOutput("armedWaitsForDone", 64'(bus.p1_ready), 64'(1));
        bus.p1_done = 1'b1;
        p2Lat.push_back(3);
        advanceCycle();
        checkOutput("armedDoneAccepted", 64'(bus.p1_ready), 64'(0));
        p1Hold = 1'b0;
        bus.p1_done = 1'b0;
        r2 = s + 9 + DRAIN;
        t = r2 + 3 + 1 + DRAIN + 1;
        while (cyc < t + 3) advanceCycle();
        expQ.delete(); expQ.push_back(s + 9);
        compareLog("stale.p1Fall", p1FallLog, expQ);
        expQ.delete(); expQ.push_back(r2);
        compareLog("stale.p2Rise", p2RiseLog, expQ);
        expQ.delete(); expQ.push_back(t);
        compareLog("stale.done", doneLog, expQ);
        expDb = ~expDb;
        checkOutput("staleStepCount", 64'(bus.step_count), 64'(1));

        applyStimulus(0, 0);

        // Phase 2 never answers: watchdog must trip after exactly 2**WDOG_W-1 RUN cycles.
        clearLogs();
        p1Lat.push_back(3);
        pulseStart(1, s);
        r2 = s + 3 + 1 + DRAIN;
        while (errLog.size() == 0 && cyc < r2 + WDOG_TIMEOUT + 10) advanceCycle();
        checkOutput("wdogP2Rise", 64'((p2RiseLog.size() > 0) ? p2RiseLog[0] : -1), 64'(r2));
        checkOutput("wdogErrCycle", 64'((errLog.size() > 0) ? errLog[0] : -1), 64'(r2 + WDOG_TIMEOUT));
        checkOutput("wdogP2ReadyLow", 64'(bus.p2_ready), 64'(0));
        checkOutput("wdogBusyLow", 64'(bus.busy), 64'(0));
        repeat (2) advanceCycle();
        checkOutput("wdogErrSticky", 64'(bus.err), 64'(1));
        applyStimulus(1, 0);

        // Abort inside the second step's phase 2, with a simultaneous start.
        clearLogs();
        la.delete(); lb.delete();
        for (int i = 0; i < 3; i++) begin
            la.push_back(int'($urandom_range(12, 1)));
            lb.push_back(int'($urandom_range(12, 4)));
            p1Lat.push_back(la[i]);
            p2Lat.push_back(lb[i]);
        end
        pulseStart(3, s);
        t = s + la[0] + 1 + DRAIN + lb[0] + 1 + DRAIN + 1;
        r2 = t + la[1] + 1 + DRAIN;
        while (cyc < r2 + 2) advanceCycle();
        checkOutput("abortPreP2Ready", 64'(bus.p2_ready), 64'(1));
        bus.abort = 1'b1;
        bus.start = 1'b1;
        bus.num_steps = STEP_W'(5);
        advanceCycle();
        checkOutput("abortBusy", 64'(bus.busy), 64'(0));
        checkOutput("abortP2Ready", 64'(bus.p2_ready), 64'(0));
        checkOutput("abortStepCount", 64'(bus.step_count), 64'(1));
        bus.abort = 1'b0;
        bus.start = 1'b0;
        repeat (4) advanceCycle();
        checkOutput("abortNoDone", 64'(doneLog.size()), 64'(0));
        checkOutput("abortStartIgnored", 64'(bus.busy), 64'(0));
        checkOutput("abortP1RiseCount", 64'(p1RiseLog.size()), 64'(2));
        expDb = ~expDb;
        checkOutput("abortDbHold", 64'(bus.double_buffer), 64'(expDb));

        // Reset during a phase 1 drain while the buffer select is high.
        clearLogs();
        target = expDb ? 0 : 1;
        la.delete(); lb.delete();
        for (int i = 0; i < 2; i++) begin
            la.push_back(int'($urandom_range(12, 1)));
            lb.push_back(int'($urandom_range(12, 1)));
            p1Lat.push_back(la[i]);
            p2Lat.push_back(lb[i]);
        end
        pulseStart(2, s);
        t = s;
        for (int i = 0; i < target; i++) t += la[i] + 1 + DRAIN + lb[i] + 1 + DRAIN + 1;
        a1 = t + la[target] + 1;
        while (cyc < a1 + 1) advanceCycle();
        checkOutput("preResetDb", 64'(bus.double_buffer), 64'(expDb ^ target[0]));
        reset = 1'b0;
        advanceCycle();
        checkOutput("midResetBusy", 64'(bus.busy), 64'(0));
        checkOutput("midResetP1Ready", 64'(bus.p1_ready), 64'(0));
        checkOutput("midResetP2Ready", 64'(bus.p2_ready), 64'(0));
        checkOutput("midResetDb", 64'(bus.double_buffer), 64'(0));
        checkOutput("midResetStepCount", 64'(bus.step_count), 64'(0));
        checkOutput("midResetDone", 64'(bus.done), 64'(0));
        reset = 1'b1;
        expDb = 1'b0;
        advanceCycle();
        applyStimulus(2, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL globalTimeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
